// File: rtl/ntt_pkg.sv
// Shared opcode encoding for the NTT modular-arithmetic pipeline.
package ntt_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_MUL   = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_BF_CT = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_BF_GS = 3'd4;

endpackage

// File: rtl/ntt_arith_lane.sv
// Combinational single-lane modular datapath: ADD/MUL/SUB and both NTT butterflies.
// Operands are assumed already reduced below q, so each add/sub needs only one correction step.
module ntt_arith_lane import ntt_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    w,
  input  logic [WIDTH-1:0]    q,
  output logic [WIDTH-1:0]    r1,
  output logic [WIDTH-1:0]    r2,
  output logic                err
);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + {1'b0, m} - {1'b0, y};
    return WIDTH'(d);
  endfunction

  function automatic logic [WIDTH-1:0] mod_mult(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    return WIDTH'(p % {{WIDTH{1'b0}}, m});
  endfunction

  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] prod_ab;
  logic [WIDTH-1:0] t_bw;
  logic [WIDTH-1:0] ct_u;
  logic [WIDTH-1:0] ct_v;
  logic [WIDTH-1:0] gs_v;

  // All three multipliers run in parallel; the opcode only steers the result mux.
  assign sum_ab  = mod_add(a, b, q);
  assign diff_ab = mod_sub(a, b, q);
  assign prod_ab = mod_mult(a, b, q);
  assign t_bw    = mod_mult(b, w, q);
  assign ct_u    = mod_add(a, t_bw, q);
  assign ct_v    = mod_sub(a, t_bw, q);
  assign gs_v    = mod_mult(diff_ab, w, q);

  always_comb begin
    r1  = '0;
    r2  = '0;
    err = 1'b0;
    case (op)
      OP_ADD:   r1 = sum_ab;
      OP_MUL:   r1 = prod_ab;
      OP_SUB:   r1 = diff_ab;
      OP_BF_CT: begin
        r1 = ct_u;
        r2 = ct_v;
      end
      OP_BF_GS: begin
        r1 = sum_ab;
        r2 = gs_v;
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ntt_arith_pipe.sv
// Multi-lane pipelined modular arithmetic engine with valid/ready flow control.
// Lane logic feeds stage 0; later stages are a plain delay line so synthesis can retime the multipliers.
module ntt_arith_pipe import ntt_pkg::*; #(
  parameter int WIDTH       = 64,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0]       in_q,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_r1,
  output logic [LANES*WIDTH-1:0] out_r2,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err
);

  logic                   adv;
  logic                   accept;
  logic                   ready_en;
  logic [LANES*WIDTH-1:0] r1_c;
  logic [LANES*WIDTH-1:0] r2_c;
  logic [LANES-1:0]       err_c;

  logic [PIPE_STAGES-1:0] vld_p;
  logic [LANES*WIDTH-1:0] r1_p  [PIPE_STAGES];
  logic [LANES*WIDTH-1:0] r2_p  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_p [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] err_p;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ntt_arith_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .op  (in_opcode),
      .a   (in_a[i*WIDTH +: WIDTH]),
      .b   (in_b[i*WIDTH +: WIDTH]),
      .w   (in_w[i*WIDTH +: WIDTH]),
      .q   (in_q),
      .r1  (r1_c[i*WIDTH +: WIDTH]),
      .r2  (r2_c[i*WIDTH +: WIDTH]),
      .err (err_c[i])
    );
  end

  // The whole pipe moves together; a stalled head beat freezes every stage.
  assign out_valid = vld_p[PIPE_STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && ready_en;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (adv) begin
        vld_p[0] <= accept;
        for (int k = 1; k < PIPE_STAGES; k++) vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // ---- stage 0 capture from lanes, stages 1..N-1 delay line ----
  always_ff @(posedge clk) begin
    if (adv) begin
      r1_p[0]  <= r1_c;
      r2_p[0]  <= r2_c;
      tag_p[0] <= in_tag;
      err_p[0] <= |err_c;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r1_p[k]  <= r1_p[k-1];
        r2_p[k]  <= r2_p[k-1];
        tag_p[k] <= tag_p[k-1];
        err_p[k] <= err_p[k-1];
      end
    end
  end

  // ---- output stage: payload is forced to zero whenever no beat is presented ----
  assign out_r1  = out_valid ? r1_p[PIPE_STAGES-1]  : '0;
  assign out_r2  = out_valid ? r2_p[PIPE_STAGES-1]  : '0;
  assign out_tag = out_valid ? tag_p[PIPE_STAGES-1] : '0;
  assign out_err = out_valid && err_p[PIPE_STAGES-1];

endmodule

// File: tb/tb_ntt_arith_pipe.sv
// Scoreboard bench for ntt_arith_pipe: directed hand-computed beats, stall, reset and a long random run.
module tb_ntt_arith_pipe;
  import ntt_pkg::*;

  localparam int WIDTH = 64;
  localparam int LANES = 4;
  localparam int PS    = 3;
  localparam int TAG_W = 8;
  localparam int LW    = LANES * WIDTH;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    logic [LW-1:0]    r1;
    logic [LW-1:0]    r2;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               acc;
    bit               chk_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_opcode = '0;
  logic [LW-1:0]    in_a = '0;
  logic [LW-1:0]    in_b = '0;
  logic [LW-1:0]    in_w = '0;
  logic [WIDTH-1:0] in_q = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [LW-1:0]    out_r1;
  logic [LW-1:0]    out_r2;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  ntt_arith_pipe #(
    .WIDTH(WIDTH), .LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_q(in_q),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_r2(out_r2), .out_tag(out_tag), .out_err(out_err)
  );

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  rdy_cmd = 1'b1;
  bit    bp_rand = 1'b0;
  word_t cur_a[LANES], cur_b[LANES], cur_w[LANES];
  word_t hr1[LANES], hr2[LANES];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rdy_cmd;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: wide arithmetic with plain % reductions.
  function automatic exp_t model_beat(input logic [2:0] op, input word_t q,
                                      input logic [TAG_W-1:0] tag, input bit lat);
    exp_t e;
    logic [2*WIDTH-1:0] A, B, W, Q, t, d;
    e.r1 = '0; e.r2 = '0; e.err = 1'b0; e.tag = tag; e.chk_lat = lat; e.acc = 0;
    Q = (2*WIDTH)'(q);
    for (int l = 0; l < LANES; l++) begin
      A = (2*WIDTH)'(cur_a[l]); B = (2*WIDTH)'(cur_b[l]); W = (2*WIDTH)'(cur_w[l]);
      case (op)
        3'd0: e.r1[l*WIDTH +: WIDTH] = WIDTH'((A + B) % Q);
        3'd1: e.r1[l*WIDTH +: WIDTH] = WIDTH'((A * B) % Q);
        3'd2: e.r1[l*WIDTH +: WIDTH] = WIDTH'((A + Q - B) % Q);
        3'd3: begin
          t = (B * W) % Q;
          e.r1[l*WIDTH +: WIDTH] = WIDTH'((A + t) % Q);
          e.r2[l*WIDTH +: WIDTH] = WIDTH'((A + Q - t) % Q);
        end
        3'd4: begin
          d = (A + Q - B) % Q;
          e.r1[l*WIDTH +: WIDTH] = WIDTH'((A + B) % Q);
          e.r2[l*WIDTH +: WIDTH] = WIDTH'((d * W) % Q);
        end
        default: e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t hand_beat(input logic [TAG_W-1:0] tag, input logic err);
    exp_t e;
    e.tag = tag; e.err = err; e.chk_lat = 1'b1; e.acc = 0;
    for (int l = 0; l < LANES; l++) begin
      e.r1[l*WIDTH +: WIDTH] = hr1[l];
      e.r2[l*WIDTH +: WIDTH] = hr2[l];
    end
    return e;
  endfunction

  task automatic set_ops(input word_t a0, a1, a2, a3, b0, b1, b2, b3, w0, w1, w2, w3);
    cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2; cur_a[3] = a3;
    cur_b[0] = b0; cur_b[1] = b1; cur_b[2] = b2; cur_b[3] = b3;
    cur_w[0] = w0; cur_w[1] = w1; cur_w[2] = w2; cur_w[3] = w3;
  endtask

  task automatic set_hand(input word_t x0, x1, x2, x3, y0, y1, y2, y3);
    hr1[0] = x0; hr1[1] = x1; hr1[2] = x2; hr1[3] = x3;
    hr2[0] = y0; hr2[1] = y1; hr2[2] = y2; hr2[3] = y3;
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at a negedge after the beat was accepted.
  task automatic send(input logic [2:0] op, input word_t q, input logic [TAG_W-1:0] tag,
                      input exp_t e);
    bit ok;
    int guard;
    in_valid = 1'b1; in_opcode = op; in_q = q; in_tag = tag;
    for (int l = 0; l < LANES; l++) begin
      in_a[l*WIDTH +: WIDTH] = cur_a[l];
      in_b[l*WIDTH +: WIDTH] = cur_b[l];
      in_w[l*WIDTH +: WIDTH] = cur_w[l];
    end
    ok = 1'b0;
    guard = 0;
    while (!ok) begin
      #1;
      if (in_ready === 1'b1) begin
        e.acc = cyc;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (!ok && guard > 2000) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: tag %0h never accepted, in_ready=%0b required 1", tag, in_ready);
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d beats still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: hold stability, stall back-pressure and in-order scoreboard comparison.
  logic [LW-1:0]    p_r1, p_r2;
  logic [TAG_W-1:0] p_tag;
  logic             p_err;
  bit               p_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_r1 !== p_r1 || out_r2 !== p_r2 ||
            out_tag !== p_tag || out_err !== p_err) begin
          n_fail++;
          $display("FAIL hold: tag %0h valid %0b while stalled, required tag %0h valid 1",
                   out_tag, out_valid, p_tag);
        end
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (in_ready !== out_ready) begin
          n_fail++;
          $display("FAIL in_ready: got %0b with out_valid=1 out_ready=%0b, required %0b",
                   in_ready, out_ready, out_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: tag %0h emitted, required none", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_r1 !== e.r1 || out_r2 !== e.r2 || out_tag !== e.tag || out_err !== e.err) begin
            n_fail++;
            $display("FAIL beat: tag %0h err %0b r1 %0h r2 %0h, required tag %0h err %0b r1 %0h r2 %0h",
                     out_tag, out_err, out_r1, out_r2, e.tag, e.err, e.r1, e.r2);
          end
          if (e.chk_lat) begin
            n_tests++;
            if (cyc - e.acc != PS) begin
              n_fail++;
              $display("FAIL latency: tag %0h took %0d cycles, required %0d", e.tag, cyc - e.acc, PS);
            end
          end
        end
      end
      p_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      p_r1 = out_r1; p_r2 = out_r2; p_tag = out_tag; p_err = out_err;
    end
  end

  initial begin
    exp_t  e;
    word_t qm;
    logic [2:0] op;
    qm = 64'h1FFF_FFFF_FFFF_FFFF;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", LW'(out_valid), '0);
    check("rst_out_r1", out_r1, '0);
    check("rst_out_r2", out_r2, '0);
    check("rst_out_tag", LW'(out_tag), '0);
    check("rst_out_err", LW'(out_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", LW'(in_ready), LW'(1));
    @(negedge clk);

    // ADD / MUL / SUB, q=97
    set_ops(60, 1, 96, 0,  50, 2, 96, 0,  0, 0, 0, 0);
    set_hand(13, 3, 95, 0,  0, 0, 0, 0);
    send(OP_ADD, 97, 8'h01, hand_beat(8'h01, 1'b0));
    set_ops(10, 96, 0, 50,  20, 96, 5, 2,  0, 0, 0, 0);
    set_hand(6, 1, 0, 3,  0, 0, 0, 0);
    send(OP_MUL, 97, 8'h02, hand_beat(8'h02, 1'b0));
    set_ops(5, 9, 0, 96,  9, 5, 96, 0,  0, 0, 0, 0);
    set_hand(93, 4, 1, 96,  0, 0, 0, 0);
    send(OP_SUB, 97, 8'h03, hand_beat(8'h03, 1'b0));
    wait_drain();

    // Butterflies, distinct operands per lane
    set_ops(3, 96, 0, 40,  5, 96, 1, 7,  2, 96, 50, 14);
    set_hand(13, 0, 50, 41,  90, 95, 47, 39);
    send(OP_BF_CT, 97, 8'h04, hand_beat(8'h04, 1'b0));
    set_hand(8, 95, 1, 47,  93, 0, 47, 74);
    send(OP_BF_GS, 97, 8'h05, hand_beat(8'h05, 1'b0));
    wait_drain();

    // Illegal opcode
    set_ops(11, 22, 33, 44,  5, 6, 7, 8,  1, 2, 3, 4);
    set_hand(0, 0, 0, 0,  0, 0, 0, 0);
    send(3'd7, 97, 8'h5A, hand_beat(8'h5A, 1'b1));
    wait_drain();

    // Ten-beat stream with a four-cycle output stall in the middle
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          set_ops(word_t'(t), word_t'(t + 1), word_t'(t + 2), word_t'(t + 3),
                  word_t'(2 * t), word_t'(90), word_t'(96 - t), word_t'(t),  0, 0, 0, 0);
          send(OP_ADD, 97, TAG_W'(t), model_beat(OP_ADD, 97, TAG_W'(t), 1'b0));
        end
      end
      begin
        repeat (5) @(posedge clk);
        rdy_cmd = 1'b0;
        repeat (4) @(posedge clk);
        rdy_cmd = 1'b1;
      end
    join
    wait_drain();

    // Reset with three beats in flight
    rdy_cmd = 1'b0;
    @(negedge clk);
    set_ops(1, 2, 3, 4,  5, 6, 7, 8,  9, 10, 11, 12);
    for (int t = 0; t < 3; t++)
      send(OP_MUL, 97, TAG_W'(8'hE0 + t), model_beat(OP_MUL, 97, TAG_W'(8'hE0 + t), 1'b0));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", LW'(out_valid), '0);
    check("midrst_out_r1", out_r1, '0);
    check("midrst_out_tag", LW'(out_tag), '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_cmd = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", LW'(in_ready), LW'(1));
    @(negedge clk);
    set_ops(60, 1, 96, 0,  50, 2, 96, 0,  0, 0, 0, 0);
    set_hand(13, 3, 95, 0,  0, 0, 0, 0);
    send(OP_ADD, 97, 8'h77, hand_beat(8'h77, 1'b0));
    wait_drain();

    // Random run, Mersenne modulus, random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      op = ($urandom_range(0, 63) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
      for (int l = 0; l < LANES; l++) begin
        cur_a[l] = {$urandom, $urandom} % qm;
        cur_b[l] = {$urandom, $urandom} % qm;
        cur_w[l] = {$urandom, $urandom} % qm;
      end
      send(op, qm, TAG_W'(i), model_beat(op, qm, TAG_W'(i), 1'b0));
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    bp_rand = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
